// File: rtl/smtlib_mul_seq_abstract.sv
// Multi-cycle abstract multiplier: one operand pair per valid/ready handshake, product half held until consumed.
// Formal builds pin a symbolic product with an SMT-LIB2 bvmul constraint; simulation uses native '*'.

`ifdef FORMAL
(* smtlib2_module *)
module smtlib_mul_seq_abstract_bvmul #(
  parameter int W = 16
) (
  (* smtlib2_comb_expr = "(= p (bvmul ea eb))" *)
  output logic         valid,
  input  logic [W-1:0] ea,
  input  logic [W-1:0] eb,
  input  logic [W-1:0] p
);
endmodule
`endif

module smtlib_mul_seq_abstract #(
  parameter int WIDTH      = 8,
  parameter int MIN_LAT    = 1,
  parameter int MAX_LAT    = 4,
  parameter int NONDET_LAT = 0,
  parameter int SIM_MODEL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_signed,
  input  logic             op_high,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam int W2 = 2 * WIDTH;
  localparam bit FIXED_LAT = (SIM_MODEL != 0) || (NONDET_LAT == 0);

  generate
    if (WIDTH < 2 || MIN_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_bad_params
      $error("smtlib_mul_seq_abstract: need WIDTH>=2, MIN_LAT>=1, MAX_LAT>=MIN_LAT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    lat;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic             cap_s, cap_h;
  logic             accept;
  logic [WIDTH-1:0] nx_a, nx_b;
  logic             nx_s, nx_h;
  logic [W2-1:0]    ea, eb, prod;
  logic [WIDTH-1:0] half;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // The multiplier sees the operands that will be held after this edge, so an
  // L==1 accept can load its result in the same edge that captures the operands.
  assign nx_a = accept ? op_a      : cap_a;
  assign nx_b = accept ? op_b      : cap_b;
  assign nx_s = accept ? op_signed : cap_s;
  assign nx_h = accept ? op_high   : cap_h;

  assign ea   = {{WIDTH{nx_s & nx_a[WIDTH-1]}}, nx_a};
  assign eb   = {{WIDTH{nx_s & nx_b[WIDTH-1]}}, nx_b};
  assign half = nx_h ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];

  generate
    if (FIXED_LAT) begin : g_lat_fixed
      assign lat = CW'(MAX_LAT);
    end else begin : g_lat_nondet
`ifdef FORMAL
      (* anyseq *) logic [CW-1:0] lat_sym;
      assign lat = lat_sym;
`else
      assign lat = CW'(MAX_LAT);
`endif
    end

    if (SIM_MODEL != 0) begin : g_prod_native
      assign prod = ea * eb;
    end else begin : g_prod_symbolic
`ifdef FORMAL
      logic bv_ok;
      (* anyseq *) logic [W2-1:0] prod_sym;
      assign prod = prod_sym;
      smtlib_mul_seq_abstract_bvmul #(.W(W2)) u_bvmul (
        .valid (bv_ok),
        .ea    (ea),
        .eb    (eb),
        .p     (prod)
      );
      always_comb assume (bv_ok);
`else
      assign prod = ea * eb;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_s      <= 1'b0;
      cap_h      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (accept) begin
      cap_a <= op_a;
      cap_b <= op_b;
      cap_s <= op_signed;
      cap_h <= op_high;
      if (lat <= CW'(1)) begin
        state      <= DONE;
        out_valid  <= 1'b1;
        out_result <= half;
      end else begin
        state      <= BUSY;
        cnt        <= lat - CW'(1);
        out_valid  <= 1'b0;
        out_result <= '0;
      end
    end else begin
      case (state)
        BUSY: begin
          if (cnt == CW'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= half;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FORMAL
  generate
    if (SIM_MODEL == 0) begin : g_formal
      logic        f_past_valid = 1'b0;
      logic        f_inflight;
      logic [CW:0] f_age;
      logic        f_enter;

      always_comb if (!f_past_valid) assume (rst);
      always_comb if (accept && !FIXED_LAT)
        assume (lat >= CW'(MIN_LAT) && lat <= CW'(MAX_LAT));

      always_ff @(posedge clk) begin
        f_past_valid <= 1'b1;
        if (rst) begin
          f_inflight <= 1'b0;
          f_age      <= '0;
        end else if (accept) begin
          f_inflight <= 1'b1;
          f_age      <= (CW+1)'(1);
        end else begin
          if (out_valid && out_ready) f_inflight <= 1'b0;
          if (f_inflight && !out_valid) f_age <= f_age + (CW+1)'(1);
        end
      end

      // A new result is presented either from idle/busy or right after a consumed one.
      assign f_enter = out_valid && (!$past(out_valid) || $past(out_ready));

      always_ff @(posedge clk) begin
        if (f_past_valid && !$past(rst) && !rst) begin
          if ($past(out_valid) && !$past(out_ready)) begin
            assert (out_valid);
            assert (out_result == $past(out_result));
          end
          assert (!out_valid || f_inflight);
          if (f_enter) begin
            assert (f_age >= (CW+1)'(MIN_LAT) && f_age <= (CW+1)'(MAX_LAT));
            cover (f_age == (CW+1)'(MIN_LAT));
            cover (f_age == (CW+1)'(MAX_LAT));
          end
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_smtlib_mul_seq_abstract.sv
// Directed bench for smtlib_mul_seq_abstract: latency, signed/unsigned halves, backpressure,
// reset abort, and a single-cycle-latency streaming instance.

module tb_smtlib_mul_seq_abstract;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid, in_ready, op_signed, op_high, out_valid, out_ready, busy;
    logic [7:0] op_a, op_b, out_result;

    logic       s_in_valid, s_in_ready, s_op_signed, s_op_high, s_out_valid, s_out_ready, s_busy;
    logic [7:0] s_op_a, s_op_b, s_out_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    smtlib_mul_seq_abstract #(
        .WIDTH(8), .MIN_LAT(1), .MAX_LAT(4), .NONDET_LAT(0), .SIM_MODEL(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_signed(op_signed), .op_high(op_high),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    smtlib_mul_seq_abstract #(
        .WIDTH(8), .MIN_LAT(1), .MAX_LAT(1), .NONDET_LAT(0), .SIM_MODEL(1)
    ) u_dut_l1 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .op_signed(s_op_signed), .op_high(s_op_high),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
        .busy(s_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, scramble the inputs afterwards, and time the result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic h, input logic [7:0] exp);
        int lat;
        op_a = a; op_b = b; op_signed = s; op_high = h; in_valid = 1'b1;
        #1 check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; op_signed = ~s; op_high = ~h;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd4);
        check_eq({tag, "_result"}, 32'(out_result), 32'(exp));
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       s, h;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'hFF, 8'h02, 1'b0, 1'b1, 8'h01},
        '{8'hFF, 8'h02, 1'b1, 1'b1, 8'hFF},
        '{8'hFF, 8'h02, 1'b1, 1'b0, 8'hFE},
        '{8'h80, 8'h7F, 1'b1, 1'b1, 8'hC0},
        '{8'h80, 8'h7F, 1'b0, 1'b1, 8'h3F},
        '{8'h80, 8'h7F, 1'b1, 1'b0, 8'h80}
    };

    logic [7:0] st_a[6]   = '{8'd3, 8'd4, 8'd5,  8'd16, 8'd255, 8'd12};
    logic [7:0] st_b[6]   = '{8'd1, 8'd6, 8'd11, 8'd16, 8'd255, 8'd13};
    logic [7:0] st_exp[6] = '{8'h03, 8'h18, 8'h37, 8'h00, 8'h01, 8'h9C};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ghost;
        int lat;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_signed = 1'b0; op_high = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_op_a = '0; s_op_b = '0; s_op_signed = 1'b0; s_op_high = 1'b0;
        s_out_ready = 1'b1;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", 32'(out_result), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // unsigned low half, exact latency
        run_op("t1", 8'd200, 8'd3, 1'b0, 1'b0, 8'h58);
        check_eq("t1_busy_done", 32'(busy), 32'd1);
        step();
        check_eq("t1_drain_valid", 32'(out_valid), 32'd0);
        check_eq("t1_drain_result", 32'(out_result), 32'd0);
        check_eq("t1_drain_busy", 32'(busy), 32'd0);

        // signed/unsigned, high/low halves at the sign boundaries
        foreach (vecs[i]) begin
            run_op($sformatf("t2_%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].h, vecs[i].exp);
            step();
        end

        // backpressure, then output handshake and new accept in the same cycle
        out_ready = 1'b0;
        run_op("t3a", 8'd5, 8'd9, 1'b0, 1'b0, 8'h2D);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t3_hold_result", 32'(out_result), 32'h2D);
            check_eq("t3_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        op_a = 8'd7; op_b = 8'd6; op_signed = 1'b0; op_high = 1'b0; in_valid = 1'b1;
        #1 check_eq("t3_same_cycle_in_ready", 32'(in_ready), 32'd1);
        check_eq("t3_same_cycle_valid", 32'(out_valid), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("t3_after_handoff_valid", 32'(out_valid), 32'd0);
        check_eq("t3_after_handoff_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        check_eq("t3b_latency", 32'(lat), 32'd4);
        check_eq("t3b_result", 32'(out_result), 32'h2A);
        step();

        // reset two cycles after accept drops the transaction
        op_a = 8'd9; op_b = 8'd9; in_valid = 1'b1;
        #1 check_eq("t4_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t4_out_valid", 32'(out_valid), 32'd0);
        check_eq("t4_out_result", 32'(out_result), 32'd0);
        check_eq("t4_in_ready_after", 32'(in_ready), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        ghost = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) ghost++;
        end
        check_eq("t4_no_ghost", 32'(ghost), 32'd0);

        // reset while a result is waiting in DONE
        out_ready = 1'b0;
        run_op("t4b", 8'd3, 8'd3, 1'b0, 1'b0, 8'h09);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check_eq("t4b_out_valid", 32'(out_valid), 32'd0);
        check_eq("t4b_out_result", 32'(out_result), 32'd0);

        // single-cycle latency stream: one result per cycle, in order
        for (int k = 0; k < 6; k++) begin
            s_op_a = st_a[k]; s_op_b = st_b[k]; s_in_valid = 1'b1;
            #1 check_eq($sformatf("t5_in_ready_%0d", k), 32'(s_in_ready), 32'd1);
            step();
            check_eq($sformatf("t5_valid_%0d", k), 32'(s_out_valid), 32'd1);
            check_eq($sformatf("t5_result_%0d", k), 32'(s_out_result), 32'(st_exp[k]));
        end
        s_in_valid = 1'b0;
        step();
        check_eq("t5_end_valid", 32'(s_out_valid), 32'd0);
        check_eq("t5_end_result", 32'(s_out_result), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
